// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the pipelined ARM
// core. Holds the program counter and drives the word address into the
// combinational instruction memory. The returned word is captured, together
// with its PC, into the decode-stage register. PC redirects come from
// execute (BranchTakenE) and writeback (PCSrcW). Stall and flush requests
// come from the hazard unit.
//
// Optional feature macro: FETCH_PERF_EN
//   defined   : FetchCount / FlushCount are live 32-bit wrapping counters
//   undefined : both ports are tied to 0 and no counter flops exist
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   IMEM_WORDS  instruction-memory depth in words; fetches at or beyond
//               this word index are flagged on AddrFaultD
//
// Ports:
//   clk           in   core clock, rising-edge
//   reset         in   asynchronous, active-high
//   StallF        in   hold PC
//   StallD        in   hold IF/ID register
//   FlushD        in   replace IF/ID contents with a bubble
//   BranchTakenE  in   execute-stage redirect to ALUResultE
//   ALUResultE    in   branch target from execute
//   PCSrcW        in   writeback redirect to ResultW (write to R15)
//   ResultW       in   R15 value from writeback
//   InstrF        in   word returned by instruction memory for PCF
//   PCF           out  fetch address, bits [1:0] always 0
//   InstrD        out  decode-stage instruction
//   PCD           out  PC of InstrD
//   PCPlus8D      out  PCD+8, architectural R15 read value
//   ValidD        out  InstrD is a real fetched instruction
//   AddrFaultD    out  InstrD came from word index >= IMEM_WORDS
//   FetchCount    out  instructions captured into decode
//   FlushCount    out  valid instructions squashed by FlushD
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        AddrFaultD,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
);

    // Word-index limit sized to match PCF[31:2] for the fault comparison.
    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    // Reset PC is word-aligned so the low bits of PCF never go non-zero.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] pc_next;
    logic        capture;
    logic        fetch_fault;

    assign capture     = !FlushD && !StallD;
    assign fetch_fault = (PCF[31:2] >= IMEM_LIMIT);

    // Next-PC selection. Redirects win over a fetch stall so a taken branch
    // is never lost while the front end is held; execute is younger than
    // writeback and therefore has priority. Alignment is forced last.
    always_comb begin
        pc_next = PCF + 32'd4;
        if (BranchTakenE) begin
            pc_next = ALUResultE;
        end else if (PCSrcW) begin
            pc_next = ResultW;
        end else if (StallF) begin
            pc_next = PCF;
        end
        pc_next[1:0] = 2'b00;
    end

    // Program counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC_ALIGNED;
        end else begin
            PCF <= pc_next;
        end
    end

    // IF/ID pipeline register. A flush leaves PCD/PCPlus8D untouched so the
    // bubble still carries the last meaningful PC; flush beats stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD     <= 32'd0;
            PCD        <= 32'd0;
            PCPlus8D   <= 32'd0;
            ValidD     <= 1'b0;
            AddrFaultD <= 1'b0;
        end else if (FlushD) begin
            InstrD     <= 32'd0;
            ValidD     <= 1'b0;
            AddrFaultD <= 1'b0;
        end else if (!StallD) begin
            InstrD     <= InstrF;
            PCD        <= PCF;
            PCPlus8D   <= PCF + 32'd8;
            ValidD     <= 1'b1;
            AddrFaultD <= fetch_fault;
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: captures into decode, and real instructions
    // (not bubbles) discarded by a flush. Both wrap silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            FetchCount <= 32'd0;
            FlushCount <= 32'd0;
        end else begin
            if (capture) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (FlushD && ValidD) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`else
    // Counters disabled: ports stay for a stable interface, tied to zero.
    assign FetchCount = 32'd0;
    assign FlushCount = 32'd0;

    logic unused_perf;
    assign unused_perf = capture;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Scoreboard bench for fetch_stage. The driver applies inputs on the falling
// edge, advances a behavioural pipeline model by one step and pushes the
// expected post-edge state into a queue; a monitor pops and compares just
// after every rising edge. Instruction memory is a pure function of the
// address: word k holds 32'hE000_0000 + k.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int IMEM_WORDS = 64;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenE;
    logic [31:0] ALUResultE;
    logic        PCSrcW;
    logic [31:0] ResultW;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus8D;
    logic        ValidD;
    logic        AddrFaultD;
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instrD;
        logic [31:0] pcD;
        logic [31:0] pc8D;
        logic        validD;
        logic        faultD;
        logic [31:0] fetchCnt;
        logic [31:0] flushCnt;
    } expT;

    expT expQ[$];

    int vectorCount = 0;
    int miscompares = 0;

    // Behavioural model state: what the architecture says the stage holds.
    logic [31:0] mPc;
    logic [31:0] mInstrD;
    logic [31:0] mPcD;
    logic [31:0] mPc8D;
    logic        mValidD;
    logic        mFaultD;
    logic [31:0] mFetch;
    logic [31:0] mFlush;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .InstrF       (InstrF),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD),
        .AddrFaultD   (AddrFaultD),
        .FetchCount   (FetchCount),
        .FlushCount   (FlushCount)
    );

    // Combinational instruction memory.
    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return 32'hE000_0000 + (pc >> 2);
    endfunction

    assign InstrF = memWord(PCF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model reset: everything to its architectural reset value.
    task automatic modelReset();
        mPc     = 32'h0;
        mInstrD = 32'h0;
        mPcD    = 32'h0;
        mPc8D   = 32'h0;
        mValidD = 1'b0;
        mFaultD = 1'b0;
        mFetch  = 32'h0;
        mFlush  = 32'h0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and predict the result of
    // the following rising edge from the pipeline rules.
    task automatic applyStimulus(input logic sF, input logic sD, input logic fD,
                                 input logic br, input logic [31:0] alu,
                                 input logic ps, input logic [31:0] res);
        expT e;
        logic [31:0] newPc;
        @(negedge clk);
        reset        = 1'b0;
        StallF       = sF;
        StallD       = sD;
        FlushD       = fD;
        BranchTakenE = br;
        ALUResultE   = alu;
        PCSrcW       = ps;
        ResultW      = res;

        if (br)      newPc = alu & ~32'd3;
        else if (ps) newPc = res & ~32'd3;
        else if (sF) newPc = mPc;
        else         newPc = mPc + 32'd4;

`ifdef FETCH_PERF_EN
        if (fD && mValidD) mFlush = mFlush + 1;
        if (!fD && !sD)    mFetch = mFetch + 1;
`endif
        if (fD) begin
            mInstrD = 32'h0;
            mValidD = 1'b0;
            mFaultD = 1'b0;
        end else if (!sD) begin
            mInstrD = memWord(mPc);
            mPcD    = mPc;
            mPc8D   = mPc + 32'd8;
            mValidD = 1'b1;
            mFaultD = ((mPc / 4) >= IMEM_WORDS);
        end
        mPc = newPc;

        e.pcf      = mPc;
        e.instrD   = mInstrD;
        e.pcD      = mPcD;
        e.pc8D     = mPc8D;
        e.validD   = mValidD;
        e.faultD   = mFaultD;
        e.fetchCnt = mFetch;
        e.flushCnt = mFlush;
        expQ.push_back(e);
    endtask

    task automatic compareAll(input expT e);
        vectorCount++;
        checkOutput("PCF",        PCF,                 e.pcf);
        checkOutput("InstrD",     InstrD,              e.instrD);
        checkOutput("PCD",        PCD,                 e.pcD);
        checkOutput("PCPlus8D",   PCPlus8D,            e.pc8D);
        checkOutput("ValidD",     {31'd0, ValidD},     {31'd0, e.validD});
        checkOutput("AddrFaultD", {31'd0, AddrFaultD}, {31'd0, e.faultD});
        checkOutput("FetchCount", FetchCount,          e.fetchCnt);
        checkOutput("FlushCount", FlushCount,          e.flushCnt);
    endtask

    // Asynchronous reset in the middle of a cycle, with a redirect still on
    // the inputs; outputs must return to reset values without a clock edge.
    task automatic midCycleReset();
        expT e;
        @(posedge clk);
        #2;
        BranchTakenE = 1'b1;
        ALUResultE   = 32'h0000_0ABC;
        reset        = 1'b1;
        #1;
        modelReset();
        e.pcf = 32'h0; e.instrD = 32'h0; e.pcD = 32'h0; e.pc8D = 32'h0;
        e.validD = 1'b0; e.faultD = 1'b0; e.fetchCnt = 32'h0; e.flushCnt = 32'h0;
        compareAll(e);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            compareAll(expQ.pop_front());
        end
    end

    initial begin
        logic sF, sD, fD, br, ps;
        logic [31:0] alu, res;

        reset = 1'b1;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; ALUResultE = 32'h0;
        PCSrcW = 1'b0; ResultW = 32'h0;
        modelReset();
        #12;

        // Straight-line fetch from reset: PCF 4, 8, 12, 16 after each edge.
        repeat (4) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        // Branch to 0x42 with flush: PCF becomes 0x40, bubble in decode.
        applyStimulus(0, 0, 1, 1, 32'h42, 0, 32'h0);
        // Both redirects under a fetch stall: execute wins.
        applyStimulus(1, 0, 0, 1, 32'h80, 1, 32'h100);
        // Writeback redirect alone.
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h20);
        // Hold fetch and decode for three cycles at 0x20, then release.
        repeat (3) applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        // Stall and flush together: the flush wins.
        applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'h0);
        // Walk across the end of memory: 0xFC clean, 0x100 faulted.
        applyStimulus(0, 0, 1, 1, 32'hF8, 0, 32'h0);
        repeat (3) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        // PC wrap from the top of the address space.
        applyStimulus(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0);
        repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);

        midCycleReset();
        repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);

        // Randomized traffic with biased control probabilities.
        for (int i = 0; i < 400; i++) begin
            sF  = ($urandom_range(0, 3) == 0);
            sD  = ($urandom_range(0, 3) == 0);
            fD  = ($urandom_range(0, 5) == 0);
            br  = ($urandom_range(0, 7) == 0);
            ps  = ($urandom_range(0, 9) == 0);
            alu = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
            res = 32'($urandom_range(0, 511));
            applyStimulus(sF, sD, fD, br, alu, ps, res);
            if (i == 200) midCycleReset();
        end

        repeat (2) @(posedge clk);
        #2;
        vectorCount++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
